// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: latches operands, holds busy for a fixed
// latency, then commits the product or quotient/remainder to the architectural HI/LO.
module mdu_ctrl #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        d_uses_md_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Result datapath, combinational from the latched operands.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] uq, ur, quot, rem;
  logic [31:0] hi_n, lo_n;
  logic        commit_en;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    a_neg = (op_q == OpDiv) && a_q[31];
    b_neg = (op_q == OpDiv) && b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    uq    = '0;
    ur    = '0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem  = a_neg ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    hi_n      = hi_q;
    lo_n      = lo_q;
    commit_en = 1'b1;
    case (op_q)
      OpMult:  {hi_n, lo_n} = prod_s;
      OpMultu: {hi_n, lo_n} = prod_u;
      OpDiv, OpDivu: begin
        hi_n      = rem;
        lo_n      = quot;
        commit_en = (b_q != 32'd0);
      end
      default: commit_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          case (op_i)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              op_d    = op_i;
              a_d     = rs_val_i;
              b_d     = rt_val_i;
              cnt_d   = (op_i == OpMult || op_i == OpMultu) ? 4'(MultCycles) : 4'(DivCycles);
              state_d = StBusy;
            end
            OpMthi:  hi_d = rs_val_i;
            OpMtlo:  lo_d = rs_val_i;
            default: ;
          endcase
        end
      end
      StBusy: begin
        // Any start seen here is dropped; the D-stage stall keeps it from happening.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (commit_en) begin
            hi_d = hi_n;
            lo_d = lo_n;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o  = (state_q == StBusy);
  assign stall_o = d_uses_md_i & (busy_o | (start_i & (op_i >= OpMult) & (op_i <= OpDivu)));
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: fixed vectors, hand-built reset sequences, then random ops against
// an arithmetic model of HI/LO and the busy/stall timing.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .op_i        (op),
    .rs_val_i    (rs_val),
    .rt_val_i    (rt_val),
    .d_uses_md_i (d_uses_md),
    .busy_o      (busy),
    .stall_o     (stall),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [2:0] o);
    return (o >= 3'd1) && (o <= 3'd4);
  endfunction

  function automatic int latency(input logic [2:0] o);
    return (o <= 3'd2) ? 5 : 10;
  endfunction

  function automatic void model_result(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] h,
                                       output logic [31:0] l);
    longint sa, sb, sp;
    longint unsigned up;
    h  = m_hi;
    l  = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin sp = sa * sb; {h, l} = sp; end
      3'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {h, l} = up; end
      3'd3: if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
      3'd4: if (b != 0) begin l = a / b; h = a % b; end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Called at negedge+1 of the issue cycle; returns at negedge+1 of the first cycle after.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic du, input bit inject, input logic [31:0] eh,
                        input logic [31:0] el);
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_uses_md = du;
    #1;
    chk("stall_at_start", {31'd0, stall}, {31'd0, du & is_md(o)});
    chk("busy_at_start", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    #1;
    if (is_md(o)) begin
      for (int i = 1; i <= latency(o); i++) begin
        chk("busy_window", {31'd0, busy}, 32'd1);
        chk("stall_window", {31'd0, stall}, {31'd0, du});
        chk("hi_hold", hi, m_hi);
        chk("lo_hold", lo, m_lo);
        start  = inject && (i == 2);
        op     = 3'($urandom_range(1, 6));
        rs_val = $urandom;
        rt_val = $urandom;
        @(negedge clk);
        start = 1'b0;
        #1;
      end
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("hi_result", hi, eh);
    chk("lo_result", lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;
    logic        rdu;

    vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{3'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{3'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E});
    vecs.push_back('{3'd5, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'h0000_000E});
    vecs.push_back('{3'd6, 32'h0000_00BB, 32'd9,        32'h0000_1234, 32'h0000_00BB});
    vecs.push_back('{3'd5, 32'h0000_00AA, 32'd9,        32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{3'd4, 32'd5,         32'd0,        32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'd7, 32'h1111_1111, 32'd2,        32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'd3, 32'd5,         32'd0,        32'hFFFF_FFFE, 32'h0000_0001});

    reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; d_uses_md = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i % 3) != 2, (i % 4) == 0,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Reset during busy cycle 4 of a div aborts it with no later commit.
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    start = 1'b1; op = 3'd3; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_commit_hi", hi, 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);

    // Reset and start together: nothing is latched.
    reset = 1'b1; start = 1'b1; op = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; op = 3'd0;
    #1;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("rst_start_lo", lo, 32'd0);
    chk("rst_start_busy_later", {31'd0, busy}, 32'd0);
    m_hi = '0;
    m_lo = '0;

    for (int k = 0; k < 60; k++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      rdu = 1'($urandom_range(0, 1));
      model_result(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, rdu, $urandom_range(0, 3) == 0, eh, el);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It latches operands for `mult`/`multu`/`div`/`divu`, models the multi-cycle latency with a busy counter, and commits results to the architectural HI/LO registers. It also services `mthi`/`mtlo` and raises the D-stage stall request when a HI/LO-using instruction must wait. W-stage writeback reads `hi`/`lo` for `mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  an E-stage instruction with a valid `op` is issued this cycle.
- `op`  in  3  1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo; 0 and 7 = no-op.
- `rs_val`  in  32  forwarded rs operand: dividend, multiplicand, or mthi/mtlo source.
- `rt_val`  in  32  forwarded rt operand: divisor or multiplier.
- `d_uses_md`  in  1  the D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy`  out  1  an operation is in flight.
- `stall`  out  1  D-stage stall request.
- `hi`  out  32  committed HI register.
- `lo`  out  32  committed LO register.

## Operation
- State: `busy`, a 4-bit down-counter `cnt`, latched `op_q`, `a_q`, `b_q`, pending results `hi_n`/`lo_n`, and committed `hi`/`lo`.
- IDLE (`busy` = 0), `start` with op 1–4:
  - latch `op_q`, `a_q` = `rs_val`, `b_q` = `rt_val`;
  - set `cnt` to `MULT_CYCLES` or `DIV_CYCLES`; set `busy` = 1.
- IDLE, `start` with op 5: `hi` <= `rs_val` at the same edge. Op 6 writes `lo` the same way. `busy` stays 0.
- IDLE, `start` with op 0 or 7: no state change.
- BUSY:
  - `cnt` decrements every edge.
  - On the edge where `cnt` = 1: commit `hi`/`lo` from the computed result, clear `busy`, reach `cnt` = 0.
  - `start` while busy is ignored, including mthi/mtlo. The stall logic guarantees this does not occur; the bench checks it is harmless.
- Arithmetic is computed from `a_q`/`b_q` and must be stable by commit. A combinational or iterative datapath is acceptable provided commit timing is exact.
  - mult: signed 64-bit product; `hi` = [63:32], `lo` = [31:0].
  - multu: same split, unsigned product.
  - div: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Special division cases:
  - 0x80000000 div 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
  - Divisor 0 (div or divu): full `DIV_CYCLES` busy, `hi`/`lo` unchanged at commit.
- `stall` = `d_uses_md` & (`busy` | (`start` & `op` ∈ {1,2,3,4})). Purely combinational.
- Reset: `busy` = 0, `cnt` = 0, `hi` = 0, `lo` = 0, `op_q`/`a_q`/`b_q` = 0, `stall` = 0 (assuming `d_uses_md` = 0). Reset mid-operation aborts the operation with no commit.

## Timing
- Start sampled at edge T0.
- `busy` is high during cycles T0+1 … T0+N, with N = 5 for mult/multu and 10 for div/divu.
- `hi`/`lo` are updated and `busy` falls at the edge ending cycle T0+N. New values are visible in cycle T0+N+1.
- A D-stage HI/LO user is stalled from the cycle of `start` through cycle T0+N, and released in T0+N+1.
- mthi/mtlo: new value is visible the cycle after `start`; no stall.
- Back-to-back: a new `start` is accepted in cycle T0+N+1.
- Simultaneous `reset` and `start`: reset wins; nothing is latched.

## Test plan
- Signed mult: `rs_val` = 0xFFFFFFFE (−2), `rt_val` = 3, `start`, op 1 → `busy` high 5 cycles, then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA in cycle 6.
- multu on the same operands: 0xFFFFFFFE × 3 → `hi` = 0x00000002, `lo` = 0xFFFFFFFA after 5 busy cycles.
- Signed div: −7 div 2 → after 10 busy cycles `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then 0x80000000 div −1 → `lo` = 0x80000000, `hi` = 0.
- Stall and back-to-back: with `d_uses_md` = 1 during a div, `stall` is high from the start cycle through busy cycle 10 and low in cycle 11. An mthi 0x1234 issued in cycle 11 gives `hi` = 0x1234 in cycle 12.
- Ignored start: op 3 with `start` during a mult's busy window → result and timing are those of the mult only.
- Divide by zero: divu 5 / 0 with `hi`/`lo` = 0xAA/0xBB beforehand → 10 busy cycles, then `hi`/`lo` remain 0xAA/0xBB.
- Reset mid-div at busy cycle 4 → next cycle `busy` = 0, `hi` = `lo` = 0, and no later commit occurs.
